// File: rtl/light_pkg.sv
// Shared state encoding and LED bank patterns for the turn/hazard light sequencer.
package light_pkg;

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF
  } state_t;

  localparam logic [5:0] PAT_IDLE  = 6'b000000;
  localparam logic [5:0] PAT_L1    = 6'b000001;
  localparam logic [5:0] PAT_L2    = 6'b000011;
  localparam logic [5:0] PAT_L3    = 6'b000111;
  localparam logic [5:0] PAT_R1    = 6'b001000;
  localparam logic [5:0] PAT_R2    = 6'b011000;
  localparam logic [5:0] PAT_R3    = 6'b111000;
  localparam logic [5:0] PAT_H_ON  = 6'b111111;
  localparam logic [5:0] PAT_H_OFF = 6'b000000;

  function automatic logic [5:0] pattern_of(input state_t s);
    logic [5:0] p;
    p = PAT_IDLE;
    case (s)
      L1:      p = PAT_L1;
      L2:      p = PAT_L2;
      L3:      p = PAT_L3;
      R1:      p = PAT_R1;
      R2:      p = PAT_R2;
      R3:      p = PAT_R3;
      H_ON:    p = PAT_H_ON;
      H_OFF:   p = PAT_H_OFF;
      default: p = PAT_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_MAX and flags the last count as the step tick.
module tick_gen #(
  parameter int unsigned TICK_MAX = 24'hFFFFFF,
  parameter int unsigned TICK_W   = 24
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_MAX);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + TICK_W'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/light_sched.sv
// Turn-signal / hazard light sequencer stepping once per prescaler tick.
// Optional PWM dimming of the LED bank is enabled with `define LIGHT_PWM_EN.
module light_sched
  import light_pkg::*;
#(
  parameter int unsigned TICK_MAX = 24'hFFFFFF,
  parameter int unsigned TICK_W   = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic [2:0] bright,
  output logic [5:0] out,
  output logic       busy,
  output logic       seq_done
);

  logic       tick;
  state_t     state, state_nx;
  logic [5:0] pat_q, pat_nx;
  logic       done_nx;

  tick_gen #(
    .TICK_MAX(TICK_MAX),
    .TICK_W  (TICK_W)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (hazard || (left && right)) state_nx = H_ON;
          else if (left)                 state_nx = L1;
          else if (right)                state_nx = R1;
        end
        L1:    state_nx = L2;
        L2:    state_nx = L3;
        L3:    begin state_nx = IDLE; done_nx = 1'b1; end
        R1:    state_nx = R2;
        R2:    state_nx = R3;
        R3:    begin state_nx = IDLE; done_nx = 1'b1; end
        H_ON:  state_nx = H_OFF;
        H_OFF: begin
          if (hazard) state_nx = H_ON;
          else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    // Pattern is derived from the next state so it lands on the same edge.
    pat_nx = pattern_of(state_nx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pat_q    <= PAT_IDLE;
      seq_done <= 1'b0;
    end else begin
      state    <= state_nx;
      pat_q    <= pat_nx;
      seq_done <= done_nx;
    end
  end

  assign busy = (state != IDLE);

`ifdef LIGHT_PWM_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign out = (pwm_cnt <= bright) ? pat_q : '0;
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign out = pat_q;
`endif

endmodule

// File: tb/tb_light_sched.sv
// Directed bench for light_sched (TICK_MAX=3): queue-based sequence model plus literal checkpoints.
module tb_light_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       left = 1'b0, right = 1'b0, hazard = 1'b0;
  logic [2:0] bright = 3'd7;
  logic [5:0] out;
  logic       busy, seq_done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  light_sched #(
    .TICK_MAX(3),
    .TICK_W  (24)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .left    (left),
    .right   (right),
    .hazard  (hazard),
    .bright  (bright),
    .out     (out),
    .busy    (busy),
    .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is a queue of LED patterns played one per tick.
  // END_MK closes a blink with a done pulse; HCHK re-decides a hazard cycle.
  localparam logic [6:0] END_MK = 7'h40;
  localparam logic [6:0] HCHK   = 7'h41;

  int unsigned edges;
  logic [6:0]  q[$];
  logic [6:0]  item;
  logic [5:0]  m_pat;
  logic        m_done;
  logic [2:0]  m_pw;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      edges  = 0;
      q.delete();
      m_pat  = 6'h00;
      m_done = 1'b0;
      m_pw   = 3'd0;
    end else begin
      edges++;
      m_pw   = m_pw + 3'd1;
      m_done = 1'b0;
      if (edges % 4 == 0) begin
        if (q.size() == 0) begin
          if (hazard || (left && right)) q = '{7'h3F, 7'h00, HCHK};
          else if (left)                 q = '{7'h01, 7'h03, 7'h07, END_MK};
          else if (right)                q = '{7'h08, 7'h18, 7'h38, END_MK};
        end
        if (q.size() != 0) begin
          item = q.pop_front();
          if (item == END_MK) begin
            m_pat  = 6'h00;
            m_done = 1'b1;
          end else if (item == HCHK) begin
            if (hazard) begin
              m_pat = 6'h3F;
              q = '{7'h00, HCHK};
            end else begin
              m_pat  = 6'h00;
              m_done = 1'b1;
            end
          end else begin
            m_pat = item[5:0];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_out;
    if (!reset) begin
`ifdef LIGHT_PWM_EN
      exp_out = (m_pw <= bright) ? m_pat : 6'h00;
`else
      exp_out = m_pat;
`endif
      chk("model_out", 32'(out), 32'(exp_out));
      chk("model_busy", 32'(busy), 32'(q.size() != 0));
      chk("model_done", 32'(seq_done), 32'(m_done));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(seq_done), 32'h0);

    // Left held from reset
    left = 1'b1;
    do_reset();
    step(4); chk("l1", 32'(out), 32'h01); chk("l1_busy", 32'(busy), 32'h1);
    step(4); chk("l2", 32'(out), 32'h03);
    step(4); chk("l3", 32'(out), 32'h07);
    step(4); chk("l_idle", 32'(out), 32'h00); chk("l_done", 32'(seq_done), 32'h1);
    step(1); chk("l_done_clr", 32'(seq_done), 32'h0);
    step(3); chk("l1_again", 32'(out), 32'h01);
    left = 1'b0;

    // Left and right together -> hazard cycle
    left = 1'b1; right = 1'b1;
    do_reset();
    step(4); chk("lr_on", 32'(out), 32'h3F);
    step(4); chk("lr_off", 32'(out), 32'h00); chk("lr_off_busy", 32'(busy), 32'h1);
    left = 1'b0; right = 1'b0;
    step(4); chk("lr_idle_busy", 32'(busy), 32'h0); chk("lr_done", 32'(seq_done), 32'h1);

    // Hazard raised during R2
    right = 1'b1;
    do_reset();
    step(8); chk("r2", 32'(out), 32'h18);
    right = 1'b0; hazard = 1'b1;
    step(4); chk("r3", 32'(out), 32'h38);
    step(4); chk("r_idle", 32'(out), 32'h00); chk("r_done", 32'(seq_done), 32'h1);
    chk("r_idle_busy", 32'(busy), 32'h0);
    step(4); chk("hz_on", 32'(out), 32'h3F);
    hazard = 1'b0;
    step(8); chk("hz_end", 32'(busy), 32'h0);

    // Reset pulsed mid-cycle in L2
    left = 1'b1;
    do_reset();
    step(8); chk("mid_l2", 32'(out), 32'h03);
    #2 reset = 1'b1;
    #1;
    chk("async_out", 32'(out), 32'h00);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_done", 32'(seq_done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(3); chk("post_rst_wait", 32'(out), 32'h00);
    step(1); chk("post_rst_l1", 32'(out), 32'h01);
    left = 1'b0;
    step(12);

    // No request for 100 cycles
    do_reset();
    step(100);
    chk("quiet_out", 32'(out), 32'h00);
    chk("quiet_busy", 32'(busy), 32'h0);

`ifdef LIGHT_PWM_EN
    // Dimmed hazard cycling
    bright = 3'd1; hazard = 1'b1;
    do_reset();
    step(40);
    hazard = 1'b0;
    step(12);
    bright = 3'd7;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/light_sched.md
LIGHT_SCHED -- requirements
Module: light_sched

Interface
REQ-001 SHALL have parameter TICK_MAX, default 24'hFFFFFF, meaning clock cycles per step minus one (tick period = TICK_MAX+1).
REQ-002 SHALL have parameter TICK_W, default 24, meaning prescaler counter width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port left  input  1  left-turn request, level.
REQ-006 SHALL have port right  input  1  right-turn request, level.
REQ-007 SHALL have port hazard  input  1  hazard request, level.
REQ-008 SHALL have port bright  input  3  PWM duty select (used only with LIGHT_PWM_EN).
REQ-009 SHALL have port out  output  6  LED bank; [2:0] left, [5:3] right.
REQ-010 SHALL have port busy  output  1  high while a sequence is active (state != IDLE).
REQ-011 SHALL have port seq_done  output  1  one-cycle pulse on the return to IDLE.

Function
REQ-012 SHALL generate tick: prescaler counts 0..TICK_MAX, asserts tick at TICK_MAX, then wraps to 0.
REQ-013 SHALL change state only on cycles where tick is high; requests are sampled only then.
REQ-014 SHALL implement states IDLE, L1, L2, L3, R1, R2, R3, H_ON, H_OFF.
REQ-015 SHALL arbitrate in IDLE by priority: hazard or (left and right) -> H_ON; else left -> L1; else right -> R1; else stay in IDLE.
REQ-016 SHALL step L1->L2->L3->IDLE and R1->R2->R3->IDLE, one state per tick, without re-arbitrating mid-sequence.
REQ-017 SHALL step H_ON->H_OFF on a tick; at H_OFF on a tick, go to H_ON if hazard is still high, else to IDLE.
REQ-018 SHALL let a request that changes mid-sequence take effect only at the next arbitration in IDLE.
REQ-019 SHALL drive registered out patterns, updated on the same edge as the state: IDLE 000000, L1 000001, L2 000011, L3 000111, R1 001000, R2 011000, R3 111000, H_ON 111111, H_OFF 000000.
REQ-020 SHALL pulse seq_done for exactly one cycle on the edge that enters IDLE from L3, R3 or H_OFF.
REQ-021 SHALL give held requests continuous blinking: one IDLE tick separates consecutive left or right sequences.

Reset
REQ-022 SHALL, on reset assertion and asynchronously, force state IDLE, prescaler 0, out 000000, busy 0, seq_done 0, and PWM counter 0.
REQ-023 SHALL abort any sequence in progress when reset is asserted; after release, the first tick occurs TICK_MAX+1 cycles later.

Configuration
REQ-024 SHALL, with LIGHT_PWM_EN defined, run a free-running 3-bit PWM counter and gate each out bit on only when pwm_cnt <= bright (bright=7 is full on, bright=0 is 1/8 duty).
REQ-025 SHALL, without LIGHT_PWM_EN, ignore bright, omit the PWM counter, and drive out directly from the pattern register.

Structure
REQ-026 SHALL place the state enum and the nine out pattern constants in shared package light_pkg.
REQ-027 SHALL implement the prescaler as sub-module tick_gen (parameters TICK_MAX and TICK_W; outputs tick).

Verification (TICK_MAX=3, so tick every 4 cycles)
REQ-028 SHALL verify left held from reset: out steps 000001, 000011, 000111, 000000 at 4-cycle intervals, seq_done pulses once, then 000001 again.
REQ-029 SHALL verify left and right raised together in IDLE: next tick out=111111, then 000000, then back to IDLE once both are dropped.
REQ-030 SHALL verify hazard raised while in R2: R3 (111000) completes, IDLE is entered, and H_ON is entered on the following tick.
REQ-031 SHALL verify reset pulsed mid-cycle in L2: out=000000 immediately without waiting for clk, and busy=0.
REQ-032 SHALL verify, with LIGHT_PWM_EN, bright=1 and H_ON held: out=111111 for 2 of every 8 cycles and 000000 otherwise.
REQ-033 SHALL verify no request: out stays 000000, busy 0, and seq_done never pulses over 100 cycles.
